// File: rtl/cpu_bus_responder_pkg.sv
// nes_bus_pkg: shared I/O offsets, CTRL bit positions and vector addresses for the CPU bus responder.
package nes_bus_pkg;
   localparam logic [2:0] IO_CTRL      = 3'd0;
   localparam logic [2:0] IO_RELOAD_LO = 3'd1;
   localparam logic [2:0] IO_RELOAD_HI = 3'd2;
   localparam logic [2:0] IO_STATUS    = 3'd3;
   localparam logic [2:0] IO_COUNT_LO  = 3'd4;
   localparam logic [15:0] IO_SIZE     = 16'd5;
   localparam int CTRL_TEN    = 0;
   localparam int CTRL_TIE    = 1;
   localparam int CTRL_AUTO   = 2;
   localparam int CTRL_NMI_EN = 3;
   localparam logic [15:0] VEC_NMI = 16'hFFFA;
   localparam logic [15:0] VEC_RST = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ = 16'hFFFE;
endpackage

// File: rtl/cpu_bus_responder_if.sv
// cpu_bus_responder_if: 6502 CPU bus between the CPU (master) and the responder (slave).
interface cpu_bus_responder_if;
   logic [15:0] Addr_bus;
   logic [7:0]  Data_bus_out;
   logic        R_nW;
   logic [7:0]  Data_bus_in;
   logic        irq;
   logic        nmi;
   modport master (output Addr_bus, Data_bus_out, R_nW, input Data_bus_in, irq, nmi);
   modport slave (input Addr_bus, Data_bus_out, R_nW, output Data_bus_in, irq, nmi);
endinterface

// File: rtl/cpu_bus_responder_irq_timer.sv
// irq_timer: 16-bit interval timer with reload, sticky pending flag and registered active-low irq.
module irq_timer import nes_bus_pkg::*; (
   input  logic        clk_ph1,
   input  logic        rst,
   input  logic        wr_ctrl,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic        wr_status,
   input  logic [7:0]  wdata,
   output logic [2:0]  ctrl,
   output logic [15:0] reload,
   output logic [7:0]  count_lo,
   output logic        pending,
   output logic        irq
);
   logic [15:0] count;
   logic        expire;
   assign expire = ctrl[CTRL_TEN] && count == 16'd0;
   assign count_lo = count[7:0];
   always_ff @(posedge clk_ph1 or negedge rst)
      if (!rst) begin
         ctrl <= '0;
         reload <= '0;
         count <= '0;
         pending <= 1'b0;
         irq <= 1'b1;
      end else begin
         if (wr_ctrl) ctrl <= wdata[2:0];
         else if (expire && !ctrl[CTRL_AUTO]) ctrl[CTRL_TEN] <= 1'b0;
         if (wr_lo) reload[7:0] <= wdata;
         if (wr_hi) reload[15:8] <= wdata;
         if (wr_ctrl && wdata[CTRL_TEN] && !ctrl[CTRL_TEN]) count <= reload;
         else if (ctrl[CTRL_TEN]) count <= expire ? (ctrl[CTRL_AUTO] ? reload : count) : count - 16'd1;
         // expiry outranks a same-cycle write-1-clear
         pending <= expire || (pending && !(wr_status && wdata[0]));
         irq <= !(pending && ctrl[CTRL_TIE]);
      end
endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: 6502 bus target with mirrored work RAM, I/O window, vector table,
// interval timer (irq) and periodic frame NMI.
module cpu_bus_responder import nes_bus_pkg::*; #(
   parameter int          RAM_AW     = 11,
   parameter logic [15:0] IO_BASE    = 16'h4020,
   parameter logic [15:0] RST_VEC    = 16'h0000,
   parameter logic [15:0] NMI_VEC    = 16'h2000,
   parameter logic [15:0] IRQ_VEC    = 16'h2000,
   parameter logic [15:0] NMI_PERIOD = 16'd29780,
   parameter logic [7:0]  NMI_LOW    = 8'd15
) (
   input logic           clk_ph1,
   input logic           rst,
   cpu_bus_responder_if.slave bus
);
   logic [7:0]  ram [2**RAM_AW];
   logic [15:0] io_diff, vec_word, reload, nmi_cnt;
   logic [2:0]  io_off, ctrl;
   logic [7:0]  io_rd, count_lo;
   logic        ram_hit, io_hit, wr_io, wr_ctrl, pending, nmi_en, nmi_q;
   assign io_diff = bus.Addr_bus - IO_BASE;
   assign io_off = io_diff[2:0];
   assign ram_hit = bus.Addr_bus < 16'h2000;
   assign io_hit = !ram_hit && io_diff < IO_SIZE;
   assign wr_io = !bus.R_nW && io_hit;
   assign wr_ctrl = wr_io && io_off == IO_CTRL;
   irq_timer u_timer (
      .clk_ph1   (clk_ph1),
      .rst       (rst),
      .wr_ctrl   (wr_ctrl),
      .wr_lo     (wr_io && io_off == IO_RELOAD_LO),
      .wr_hi     (wr_io && io_off == IO_RELOAD_HI),
      .wr_status (wr_io && io_off == IO_STATUS),
      .wdata     (bus.Data_bus_out),
      .ctrl      (ctrl),
      .reload    (reload),
      .count_lo  (count_lo),
      .pending   (pending),
      .irq       (bus.irq)
   );
   always_ff @(posedge clk_ph1)
      if (!bus.R_nW && ram_hit) ram[bus.Addr_bus[RAM_AW-1:0]] <= bus.Data_bus_out;
   // while disabled the counter sits at 0, so enabling always starts a fresh low pulse
   always_ff @(posedge clk_ph1 or negedge rst)
      if (!rst) begin
         nmi_en <= 1'b0;
         nmi_cnt <= '0;
         nmi_q <= 1'b1;
      end else begin
         if (wr_ctrl) nmi_en <= bus.Data_bus_out[CTRL_NMI_EN];
         nmi_cnt <= (!nmi_en || nmi_cnt == NMI_PERIOD - 16'd1) ? 16'd0 : nmi_cnt + 16'd1;
         nmi_q <= !(nmi_en && nmi_cnt < {8'd0, NMI_LOW});
      end
   assign bus.nmi = nmi_q;
   always_comb begin
      io_rd = io_off == IO_CTRL ? {4'b0, nmi_en, ctrl} :
              io_off == IO_RELOAD_LO ? reload[7:0] :
              io_off == IO_RELOAD_HI ? reload[15:8] :
              io_off == IO_STATUS ? {7'b0, pending} : count_lo;
      vec_word = bus.Addr_bus[15:1] == VEC_NMI[15:1] ? NMI_VEC :
                 bus.Addr_bus[15:1] == VEC_RST[15:1] ? RST_VEC :
                 bus.Addr_bus[15:1] == VEC_IRQ[15:1] ? IRQ_VEC : 16'h0000;
   end
   assign bus.Data_bus_in = ram_hit ? ram[bus.Addr_bus[RAM_AW-1:0]] : io_hit ? io_rd :
                            bus.Addr_bus[0] ? vec_word[15:8] : vec_word[7:0];
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: vector table, randomized memory-map model and timer/NMI/reset sequences.
module tb_cpu_bus_responder;
   logic clk_ph1 = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 clk_ph1 = ~clk_ph1;
   cpu_bus_responder_if bus();
   cpu_bus_responder #(.NMI_PERIOD(16'd40), .NMI_LOW(8'd4)) dut (
      .clk_ph1 (clk_ph1),
      .rst     (rst),
      .bus     (bus)
   );
   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        rnw;
      logic [7:0]  exp;
   } vec_t;
   vec_t        vt[$];
   logic [7:0]  mram [2048];
   bit          mval [2048];
   logic [15:0] mrel;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk_ph1);
      bus.Addr_bus = a;
      bus.Data_bus_out = d;
      bus.R_nW = 1'b0;
      @(negedge clk_ph1);
      bus.R_nW = 1'b1;
   endtask

   task automatic rchk(input string name, input logic [15:0] a, input logic [7:0] e);
      bus.R_nW = 1'b1;
      bus.Addr_bus = a;
      #1 check(name, {8'h00, bus.Data_bus_in}, {8'h00, e});
   endtask

   function automatic bit model_read(input logic [15:0] a, output logic [7:0] e);
      e = 8'h00;
      if (a < 16'h2000) begin
         if (!mval[a % 2048]) return 1'b0;
         e = mram[a % 2048];
      end else if (a >= 16'h4020 && a <= 16'h4024)
         e = a == 16'h4021 ? mrel[7:0] : a == 16'h4022 ? mrel[15:8] : 8'h00;
      else if (a == 16'hFFFB || a == 16'hFFFF)
         e = 8'h20;
      return 1'b1;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] a;
      logic [7:0]  e;
      int          r, rl[2];
      bit          pend, pend_prev, clr;
      bus.Addr_bus = 16'h0000;
      bus.Data_bus_out = 8'h00;
      bus.R_nW = 1'b1;
      repeat (3) @(negedge clk_ph1);
      check("reset irq", bus.irq, 1'b1);
      check("reset nmi", bus.nmi, 1'b1);
      rchk("reset ctrl", 16'h4020, 8'h00);
      rchk("reset status", 16'h4023, 8'h00);
      rchk("reset count", 16'h4024, 8'h00);
      @(negedge clk_ph1);
      rst = 1'b1;

      vt.push_back('{16'h0003, 8'h5A, 1'b0, 8'h00});
      vt.push_back('{16'h0803, 8'h00, 1'b1, 8'h5A});
      vt.push_back('{16'h1803, 8'h00, 1'b1, 8'h5A});
      vt.push_back('{16'h2003, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'hFFFC, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'hFFFD, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'hFFFA, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'hFFFB, 8'h00, 1'b1, 8'h20});
      vt.push_back('{16'hFFFE, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'hFFFF, 8'h00, 1'b1, 8'h20});
      vt.push_back('{16'h07FF, 8'hA5, 1'b0, 8'h00});
      vt.push_back('{16'h1FFF, 8'h00, 1'b1, 8'hA5});
      vt.push_back('{16'hFFFA, 8'h11, 1'b0, 8'h00});
      vt.push_back('{16'hFFFA, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'h401F, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'h4025, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'h4021, 8'hC3, 1'b0, 8'h00});
      vt.push_back('{16'h4021, 8'h00, 1'b1, 8'hC3});
      vt.push_back('{16'h4022, 8'h3C, 1'b0, 8'h00});
      vt.push_back('{16'h4022, 8'h00, 1'b1, 8'h3C});
      vt.push_back('{16'h4024, 8'hFF, 1'b0, 8'h00});
      vt.push_back('{16'h4024, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'h4020, 8'h00, 1'b1, 8'h00});
      vt.push_back('{16'h2003, 8'h77, 1'b0, 8'h00});
      vt.push_back('{16'h2003, 8'h00, 1'b1, 8'h00});
      foreach (vt[i]) begin
         if (!vt[i].rnw) wr(vt[i].addr, vt[i].data);
         else rchk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
      end

      mrel = 16'h3CC3;
      mval[3] = 1'b1;
      mram[3] = 8'h5A;
      mval[2047] = 1'b1;
      mram[2047] = 8'hA5;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         a = r < 55 ? 16'($urandom_range(0, 16'h1FFF)) :
             r < 70 ? 16'h4020 + 16'($urandom_range(1, 2)) :
             r < 78 ? 16'h4020 + 16'($urandom_range(0, 4)) :
             r < 88 ? 16'hFFFA + 16'($urandom_range(0, 5)) : 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 1) == 1 && a != 16'h4020 && a != 16'h4023) begin
            e = 8'($urandom);
            wr(a, e);
            if (a < 16'h2000) begin
               mram[a % 2048] = e;
               mval[a % 2048] = 1'b1;
            end
            if (a == 16'h4021) mrel[7:0] = e;
            if (a == 16'h4022) mrel[15:8] = e;
         end else if (model_read(a, e))
            rchk($sformatf("rand rd %h", a), a, e);
      end

      // one-shot timer: irq falls reload+2 edges after the enabling write
      rl[0] = 5;
      rl[1] = 0;
      foreach (rl[j]) begin
         wr(16'h4021, 8'(rl[j]));
         wr(16'h4022, 8'h00);
         wr(16'h4020, 8'h03);
         for (int k = 1; k <= rl[j] + 2; k++) begin
            @(negedge clk_ph1);
            check($sformatf("oneshot%0d irq k%0d", rl[j], k), bus.irq, k < rl[j] + 2);
            if (k <= rl[j]) rchk($sformatf("oneshot%0d count k%0d", rl[j], k), 16'h4024, 8'(rl[j] - k));
         end
         rchk("oneshot ctrl ten off", 16'h4020, 8'h02);
         rchk("oneshot pending", 16'h4023, 8'h01);
         wr(16'h4023, 8'h01);
         check("irq held at clear edge", bus.irq, 1'b0);
         @(negedge clk_ph1);
         check("irq released", bus.irq, 1'b1);
         rchk("pending cleared", 16'h4023, 8'h00);
      end

      // auto-reload: expiries every reload+1 edges, clears at edges 6 and 12
      wr(16'h4021, 8'h03);
      wr(16'h4020, 8'h07);
      pend = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         clr = (k == 6 || k == 12);
         bus.Addr_bus = 16'h4023;
         bus.Data_bus_out = 8'h01;
         bus.R_nW = !clr;
         @(negedge clk_ph1);
         pend_prev = pend;
         pend = (k % 4 == 0) || (pend && !clr);
         rchk($sformatf("auto pending k%0d", k), 16'h4023, {7'b0, pend});
         check($sformatf("auto irq k%0d", k), bus.irq, !pend_prev);
      end
      wr(16'h4020, 8'h00);
      wr(16'h4023, 8'h01);
      rchk("auto stopped", 16'h4023, 8'h00);

      // NMI pulse train: low 4 of every 40 edges
      wr(16'h4020, 8'h08);
      for (int k = 1; k <= 82; k++) begin
         @(negedge clk_ph1);
         check($sformatf("nmi k%0d", k), bus.nmi, ((k - 1) % 40) >= 4);
      end
      wr(16'h4020, 8'h00);
      check("nmi low at disable edge", bus.nmi, 1'b0);
      @(negedge clk_ph1);
      check("nmi released", bus.nmi, 1'b1);
      repeat (45) begin
         @(negedge clk_ph1);
         check("nmi stays high", bus.nmi, 1'b1);
      end

      // asynchronous reset while both interrupts are asserted
      wr(16'h4021, 8'h00);
      wr(16'h4022, 8'h00);
      wr(16'h4020, 8'h0B);
      repeat (2) @(negedge clk_ph1);
      check("pre-reset irq", bus.irq, 1'b0);
      check("pre-reset nmi", bus.nmi, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("async reset irq", bus.irq, 1'b1);
      check("async reset nmi", bus.nmi, 1'b1);
      rchk("async reset ctrl", 16'h4020, 8'h00);
      rchk("async reset status", 16'h4023, 8'h00);
      @(negedge clk_ph1);
      rst = 1'b1;
      repeat (5) @(negedge clk_ph1);
      check("post-reset irq", bus.irq, 1'b1);
      check("post-reset nmi", bus.nmi, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
